dcache_data_ctrl: RTL and testbench
===================================

# dcache_data_ctrl

Sequencer for the L1 D-cache 128-bit data array (32 sets × 4 words). It arbitrates between CPU hit accesses (word read / byte-masked word write) and line refills arriving as four 32-bit beats, and produces the array's CS/OE/WEB/A/DI command, one command per cycle. It sits between the cache controller FSM and the data array wrapper.

## Interface
Parameters:
- IDX_W, 5, set index width
- BEATS, 4, refill beats per 128-bit line (fixed; no other value supported)

Ports:
- CK  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_idx  in  IDX_W  set index
- cpu_off  in  2  word offset within the line
- cpu_wstrb  in  4  byte strobes, active high
- cpu_wdata  in  32  write data
- cpu_gnt  out  1  combinational grant; request accepted this cycle
- cpu_rvalid  out  1  one-cycle read-data-valid pulse
- cpu_rdata  out  32  read data, valid only with cpu_rvalid
- fill_start  in  1  begin refill; single-cycle pulse
- fill_idx  in  IDX_W  refill set index, sampled with fill_start
- fill_off  in  2  critical word offset, sampled with fill_start
- fill_valid  in  1  beat valid
- fill_data  in  32  beat data, beat 0 = word 0
- fill_ready  out  1  beat accepted when fill_valid && fill_ready
- fill_done  out  1  one-cycle pulse on the line-write cycle
- busy  out  1  state != IDLE
- da_CS  out  1  array chip select, active high
- da_OE  out  1  array output enable
- da_WEB  out  16  per-byte write enable, active low
- da_A  out  IDX_W  array address
- da_DI  out  128  array write data
- da_DO  in  128  array read data, valid the cycle after a read command

## Operation
- States: IDLE, ISSUE, RESP, COLLECT, LWRITE.
- IDLE: fill_start → COLLECT; latch fill_idx and fill_off; clear beat count. Else cpu_req → cpu_gnt=1; latch we/idx/off/wstrb/wdata; → ISSUE. fill_start and cpu_req together: fill wins, cpu_gnt=0, and the CPU keeps cpu_req asserted.
- cpu_gnt is asserted only in IDLE.
- ISSUE: drive da_CS=1, da_A=idx.
  - Write: da_WEB bits [4·off+3 : 4·off] = ~wstrb, all other bits 1; da_DI = wdata replicated ×4; → IDLE. wstrb=0 leaves WEB all ones, which is legal and a no-op.
  - Read: da_WEB=16'hFFFF → RESP.
- RESP: da_OE=1; cpu_rvalid=1; cpu_rdata = da_DO[32·off +: 32]; → IDLE.
- COLLECT: fill_ready=1. Each handshake writes fill_data into line buffer word[cnt], then cnt++. The handshake with cnt==3 → LWRITE. fill_start and cpu_req are ignored here; cpu_gnt=0.
- LWRITE: da_CS=1, da_WEB=16'h0000, da_A=fill_idx, da_DI=line buffer; fill_done=1; → IDLE.
- Array command outputs are 0 outside ISSUE/LWRITE (da_WEB=16'hFFFF). da_OE is 0 outside RESP.

## Timing
- Reset: state=IDLE, cnt=0. Outputs: cpu_gnt=0, cpu_rvalid=0, cpu_rdata=0, fill_ready=0, fill_done=0, busy=0, da_CS=0, da_OE=0, da_WEB=16'hFFFF, da_A=0, da_DI=0. Line buffer is cleared.
- Reset during COLLECT: the partial line is discarded; no LWRITE, no fill_done.
- Read: grant in cycle T, command in T+1, cpu_rvalid in T+2. Minimum spacing between grants is 3 cycles.
- Write: grant in T, command in T+1. Next grant is possible at T+2.
- Refill: 4 handshakes minimum (bubbles allowed), then LWRITE on the cycle after the 4th handshake. The next grant is possible on the cycle after LWRITE.
- fill_valid outside COLLECT is ignored.

## Configuration
- DCACHE_CRIT_FWD_EN defined: when the COLLECT handshake with cnt==fill_off occurs, cpu_rvalid pulses on the next cycle with cpu_rdata = that beat. No cpu_gnt is involved; the controller owns the miss. This pulse never collides with RESP, because RESP cannot occur during a fill.
- Not defined: fill_off is sampled but unused, and a fill never pulses cpu_rvalid.

## Test plan
- Reset: assert rst mid-COLLECT after 2 beats → all outputs at reset values next cycle, da_WEB=16'hFFFF; no fill_done ever appears.
- CPU write: idx=5, off=2, wstrb=4'b0101, wdata=32'hAABBCCDD → T+1 shows da_CS=1, da_A=5, da_WEB=16'hFAFF, da_DI=AABBCCDD×4.
- CPU read: preload set 7 with 128'h4444…_3333…_2222…_1111…, read off=3 → cpu_rvalid at T+2 with 32'h44444444; da_OE=1 in that same cycle.
- Refill with bubbles: fill_idx=9, beats 11111111/22222222/33333333/44444444 with one idle cycle between beats → LWRITE shows da_WEB=0, da_A=9, da_DI=128'h44444444_33333333_22222222_11111111, fill_done=1 for exactly one cycle.
- Collision: fill_start and cpu_req in the same IDLE cycle → cpu_gnt=0, fill completes first, cpu_gnt=1 on the cycle after LWRITE.
- DCACHE_CRIT_FWD_EN: fill_off=2 → cpu_rvalid with 33333333 one cycle after the 3rd handshake. With the macro undefined → no cpu_rvalid during the fill.

Source files
------------

// File: rtl/dcache_data_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_data_ctrl
//
// Sequencer for the L1 D-cache 128-bit data array (32 sets x 4 words).
// Arbitrates CPU hit accesses (word read, byte-masked word write) against
// line refills delivered as four 32-bit beats, and issues one array command
// (CS/OE/WEB/A/DI) per cycle.
//
// Optional feature macro: DCACHE_CRIT_FWD_EN
//   Defined: the refill beat whose index equals the latched critical-word
//   offset is forwarded to the CPU as a cpu_rvalid pulse one cycle after its
//   handshake. Undefined: fill_off is ignored and fills never pulse cpu_rvalid.
//
// Ports:
//   CK, rst                 clock (rising edge), synchronous active-high reset
//   cpu_req/we/idx/off/wstrb/wdata   CPU access request, held until granted
//   cpu_gnt                 combinational grant (IDLE only, refill has priority)
//   cpu_rvalid, cpu_rdata   one-cycle read-data pulse and data
//   fill_start/idx/off      refill start pulse with set index and critical word
//   fill_valid/data/ready   beat handshake, beat 0 = word 0
//   fill_done               one-cycle pulse on the line-write cycle
//   busy                    controller not idle
//   da_CS/OE/WEB/A/DI       data array command (WEB active-low per byte)
//   da_DO                   array read data, valid the cycle after a read
// -----------------------------------------------------------------------------
module dcache_data_ctrl #(
   parameter int IDX_W = 5,
   parameter int BEATS = 4
) (
   input  logic             CK,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [IDX_W-1:0] cpu_idx,
   input  logic [1:0]       cpu_off,
   input  logic [3:0]       cpu_wstrb,
   input  logic [31:0]      cpu_wdata,
   output logic             cpu_gnt,
   output logic             cpu_rvalid,
   output logic [31:0]      cpu_rdata,
   input  logic             fill_start,
   input  logic [IDX_W-1:0] fill_idx,
   input  logic [1:0]       fill_off,
   input  logic             fill_valid,
   input  logic [31:0]      fill_data,
   output logic             fill_ready,
   output logic             fill_done,
   output logic             busy,
   output logic             da_CS,
   output logic             da_OE,
   output logic [15:0]      da_WEB,
   output logic [IDX_W-1:0] da_A,
   output logic [127:0]     da_DI,
   input  logic [127:0]     da_DO
);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StResp,
      StCollect,
      StLwrite
   } state_e;

   localparam logic [1:0] LastBeat = 2'(BEATS - 1);

   state_e              state_q;
   logic                we_q;
   logic [IDX_W-1:0]    idx_q;
   logic [1:0]          off_q;
   logic [3:0]          wstrb_q;
   logic [31:0]         wdata_q;
   logic [IDX_W-1:0]    fidx_q;
   logic [1:0]          cnt_q;
   logic [3:0][31:0]    lbuf_q;   // word 0 in the low 32 bits, matches da_DI layout

`ifdef DCACHE_CRIT_FWD_EN
   logic [1:0]          foff_q;
   logic                fwd_q;
   logic [31:0]         fwd_data_q;
`else
   logic                unused_fill_off;
   assign unused_fill_off = ^fill_off;
`endif

   // Refill wins over a simultaneous CPU request; the CPU keeps cpu_req high.
   assign cpu_gnt = (state_q == StIdle) && cpu_req && !fill_start && !rst;

   always_ff @(posedge CK) begin
      if (rst) begin
         state_q    <= StIdle;
         we_q       <= 1'b0;
         idx_q      <= '0;
         off_q      <= '0;
         wstrb_q    <= '0;
         wdata_q    <= '0;
         fidx_q     <= '0;
         cnt_q      <= '0;
         lbuf_q     <= '0;
`ifdef DCACHE_CRIT_FWD_EN
         foff_q     <= '0;
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
`endif
      end else begin
`ifdef DCACHE_CRIT_FWD_EN
         fwd_q <= 1'b0;
`endif
         case (state_q)
            StIdle: begin
               if (fill_start) begin
                  state_q <= StCollect;
                  fidx_q  <= fill_idx;
                  cnt_q   <= '0;
`ifdef DCACHE_CRIT_FWD_EN
                  foff_q  <= fill_off;
`endif
               end else if (cpu_req) begin
                  state_q <= StIssue;
                  we_q    <= cpu_we;
                  idx_q   <= cpu_idx;
                  off_q   <= cpu_off;
                  wstrb_q <= cpu_wstrb;
                  wdata_q <= cpu_wdata;
               end
            end
            StIssue: state_q <= we_q ? StIdle : StResp;
            StResp:  state_q <= StIdle;
            StCollect: begin
               if (fill_valid) begin
                  lbuf_q[cnt_q] <= fill_data;
                  cnt_q         <= cnt_q + 2'd1;
                  if (cnt_q == LastBeat) begin
                     state_q <= StLwrite;
                  end
`ifdef DCACHE_CRIT_FWD_EN
                  if (cnt_q == foff_q) begin
                     fwd_q      <= 1'b1;
                     fwd_data_q <= fill_data;
                  end
`endif
               end
            end
            StLwrite: state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

   // Moore-style decode of the array command from the state register.
   always_comb begin
      busy       = (state_q != StIdle);
      fill_ready = (state_q == StCollect);
      fill_done  = (state_q == StLwrite);
      da_CS      = 1'b0;
      da_OE      = 1'b0;
      da_WEB     = 16'hFFFF;
      da_A       = '0;
      da_DI      = '0;
      cpu_rvalid = 1'b0;
      cpu_rdata  = '0;
      case (state_q)
         StIssue: begin
            da_CS = 1'b1;
            da_A  = idx_q;
            if (we_q) begin
               // One WEB nibble per word: bytes of word off live at [4*off +: 4].
               da_WEB[{off_q, 2'b00} +: 4] = ~wstrb_q;
               da_DI = {4{wdata_q}};
            end
         end
         StResp: begin
            da_OE      = 1'b1;
            cpu_rvalid = 1'b1;
            cpu_rdata  = da_DO[{off_q, 5'b00000} +: 32];
         end
         StLwrite: begin
            da_CS  = 1'b1;
            da_WEB = 16'h0000;
            da_A   = fidx_q;
            da_DI  = lbuf_q;
         end
         default: ;
      endcase
`ifdef DCACHE_CRIT_FWD_EN
      // Cannot collide with RESP: a fill and a CPU read never overlap.
      if (fwd_q) begin
         cpu_rvalid = 1'b1;
         cpu_rdata  = fwd_data_q;
      end
`endif
   end

endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Table-driven bench for dcache_data_ctrl: each record is one clock cycle of
// inputs plus the outputs expected in that cycle.
module tb_dcache_data_ctrl;

   logic          CK = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we;
   logic [4:0]    cpu_idx;
   logic [1:0]    cpu_off;
   logic [3:0]    cpu_wstrb;
   logic [31:0]   cpu_wdata;
   logic          cpu_gnt, cpu_rvalid;
   logic [31:0]   cpu_rdata;
   logic          fill_start;
   logic [4:0]    fill_idx;
   logic [1:0]    fill_off;
   logic          fill_valid;
   logic [31:0]   fill_data;
   logic          fill_ready, fill_done, busy;
   logic          da_CS, da_OE;
   logic [15:0]   da_WEB;
   logic [4:0]    da_A;
   logic [127:0]  da_DI, da_DO;

`ifdef DCACHE_CRIT_FWD_EN
   localparam bit Crit = 1'b1;
`else
   localparam bit Crit = 1'b0;
`endif

   localparam logic [127:0] Line = 128'h44444444_33333333_22222222_11111111;

   always #5 CK = ~CK;

   dcache_data_ctrl #(.IDX_W(5), .BEATS(4)) dut (
      .CK(CK), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_idx(cpu_idx), .cpu_off(cpu_off),
      .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .fill_start(fill_start), .fill_idx(fill_idx), .fill_off(fill_off),
      .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
      .fill_done(fill_done), .busy(busy),
      .da_CS(da_CS), .da_OE(da_OE), .da_WEB(da_WEB), .da_A(da_A), .da_DI(da_DI),
      .da_DO(da_DO)
   );

   typedef struct {
      logic          rst, req, we;
      logic [4:0]    idx;
      logic [1:0]    off;
      logic [3:0]    strb;
      logic [31:0]   wdata;
      logic          fs;
      logic [4:0]    fidx;
      logic [1:0]    foff;
      logic          fv;
      logic [31:0]   fdata;
      logic [127:0]  dout;
      logic          gnt, rv;
      logic [31:0]   rdata;
      logic          fr, fd, bsy, cs, oe;
      logic [15:0]   web;
      logic [4:0]    a;
      logic [127:0]  di;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   function automatic vec_t base();
      vec_t t;
      t.rst = 0; t.req = 0; t.we = 0; t.idx = 0; t.off = 0; t.strb = 0; t.wdata = 0;
      t.fs = 0; t.fidx = 0; t.foff = 0; t.fv = 0; t.fdata = 0; t.dout = 0;
      t.gnt = 0; t.rv = 0; t.rdata = 0; t.fr = 0; t.fd = 0; t.bsy = 0;
      t.cs = 0; t.oe = 0; t.web = 16'hFFFF; t.a = 0; t.di = 0;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Drive one cycle's inputs just after the edge, compare just before the next.
   task automatic apply(input vec_t t, input string nm);
      @(posedge CK);
      #1;
      rst = t.rst; cpu_req = t.req; cpu_we = t.we; cpu_idx = t.idx; cpu_off = t.off;
      cpu_wstrb = t.strb; cpu_wdata = t.wdata; fill_start = t.fs; fill_idx = t.fidx;
      fill_off = t.foff; fill_valid = t.fv; fill_data = t.fdata; da_DO = t.dout;
      #1;
      chk({nm, ".gnt"},   128'(cpu_gnt),    128'(t.gnt));
      chk({nm, ".rvalid"}, 128'(cpu_rvalid), 128'(t.rv));
      chk({nm, ".rdata"}, 128'(cpu_rdata),  128'(t.rdata));
      chk({nm, ".fready"}, 128'(fill_ready), 128'(t.fr));
      chk({nm, ".fdone"}, 128'(fill_done),  128'(t.fd));
      chk({nm, ".busy"},  128'(busy),       128'(t.bsy));
      chk({nm, ".cs"},    128'(da_CS),      128'(t.cs));
      chk({nm, ".oe"},    128'(da_OE),      128'(t.oe));
      chk({nm, ".web"},   128'(da_WEB),     128'(t.web));
      chk({nm, ".a"},     128'(da_A),       128'(t.a));
      chk({nm, ".di"},    da_DI,            t.di);
   endtask

   vec_t vq[$];
   vec_t t;

   initial begin
      // ---- vector table ----
      t = base(); t.rst = 1; vq.push_back(t);                                // 0 reset
      t = base(); t.req = 1; t.we = 1; t.idx = 5; t.off = 2; t.strb = 4'b0101;
      t.wdata = 32'hAABBCCDD; t.gnt = 1; vq.push_back(t);                   // 1 write grant
      t = base(); t.bsy = 1; t.cs = 1; t.a = 5; t.web = 16'hFAFF;
      t.di = {4{32'hAABBCCDD}}; vq.push_back(t);                            // 2 write cmd
      t = base(); t.req = 1; t.idx = 7; t.off = 3; t.gnt = 1; vq.push_back(t); // 3 T+2 grant
      t = base(); t.bsy = 1; t.cs = 1; t.a = 7; vq.push_back(t);             // 4 read cmd
      t = base(); t.req = 1; t.idx = 7; t.dout = Line; t.bsy = 1; t.oe = 1;
      t.rv = 1; t.rdata = 32'h44444444; vq.push_back(t);                    // 5 resp, no gnt
      t = base(); t.req = 1; t.idx = 7; t.off = 0; t.dout = Line; t.gnt = 1;
      vq.push_back(t);                                                      // 6 T+3 grant
      t = base(); t.bsy = 1; t.cs = 1; t.a = 7; vq.push_back(t);             // 7
      t = base(); t.dout = Line; t.bsy = 1; t.oe = 1; t.rv = 1;
      t.rdata = 32'h11111111; vq.push_back(t);                              // 8 resp off 0
      t = base(); t.fs = 1; t.fidx = 9; t.foff = 2; t.req = 1; t.we = 1; t.idx = 3;
      t.strb = 4'hF; t.wdata = 32'hDEADBEEF; vq.push_back(t);               // 9 collision
      for (int b = 0; b < 7; b++) begin                                     // 10..16 beats
         t = base(); t.req = 1; t.we = 1; t.idx = 3; t.strb = 4'hF;
         t.wdata = 32'hDEADBEEF; t.fr = 1; t.bsy = 1;
         if (b % 2 == 0) begin
            t.fv = 1; t.fdata = {8{4'(b / 2 + 1)}};
         end else begin
            t.fs = 1; t.fidx = 1;  // ignored while collecting
            t.fv = 0; t.fdata = 32'hBAD0BAD0;
         end
         if (b == 5) begin
            t.rv = Crit; t.rdata = Crit ? 32'h33333333 : 32'h0;
         end
         vq.push_back(t);
      end
      t = base(); t.req = 1; t.we = 1; t.idx = 3; t.strb = 4'hF; t.wdata = 32'hDEADBEEF;
      t.bsy = 1; t.cs = 1; t.web = 16'h0000; t.a = 9; t.di = Line; t.fd = 1;
      vq.push_back(t);                                                      // 17 LWRITE
      t = base(); t.req = 1; t.we = 1; t.idx = 3; t.strb = 4'hF; t.wdata = 32'hDEADBEEF;
      t.gnt = 1; vq.push_back(t);                                           // 18 grant after
      t = base(); t.bsy = 1; t.cs = 1; t.a = 3; t.web = 16'hFFF0;
      t.di = {4{32'hDEADBEEF}}; vq.push_back(t);                            // 19
      t = base(); t.fv = 1; t.fdata = 32'h55555555; t.req = 1; t.we = 1; t.idx = 1;
      t.off = 1; t.strb = 0; t.wdata = 32'h12345678; t.gnt = 1; vq.push_back(t); // 20
      t = base(); t.fv = 1; t.bsy = 1; t.cs = 1; t.a = 1; t.web = 16'hFFFF;
      t.di = {4{32'h12345678}}; vq.push_back(t);                            // 21 wstrb=0
      t = base(); t.fv = 1; vq.push_back(t);                                // 22 fv ignored

      rst = 1; cpu_req = 0; cpu_we = 0; cpu_idx = 0; cpu_off = 0; cpu_wstrb = 0;
      cpu_wdata = 0; fill_start = 0; fill_idx = 0; fill_off = 0; fill_valid = 0;
      fill_data = 0; da_DO = 0;
      repeat (2) @(posedge CK);

      foreach (vq[i]) apply(vq[i], $sformatf("v%0d", i));

      // ---- reset in the middle of a refill ----
      t = base(); t.fs = 1; t.fidx = 4; t.foff = 1; apply(t, "rs.start");
      t = base(); t.fv = 1; t.fdata = 32'hA0A0A0A0; t.fr = 1; t.bsy = 1; apply(t, "rs.b0");
      t = base(); t.fv = 1; t.fdata = 32'hA1A1A1A1; t.fr = 1; t.bsy = 1; apply(t, "rs.b1");
      t = base(); t.rst = 1; t.fv = 1; t.fdata = 32'hA2A2A2A2; t.fr = 1; t.bsy = 1;
      t.rv = Crit; t.rdata = Crit ? 32'hA1A1A1A1 : 32'h0; apply(t, "rs.rst");
      for (int c = 0; c < 6; c++) begin
         t = base(); t.fv = 1; t.fdata = 32'hA3A3A3A3;
         apply(t, $sformatf("rs.after%0d", c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
